// File: rtl/div_sched_if.sv
// div_sched_if: bundles the two requester handshakes, their divider
// settings and the shared divider status into one bus.
// master = requester side, slave = the div_sched scheduler.
interface div_sched_if #(
  parameter int CNT_W   = 27,
  parameter int BURST_W = 8
);
  logic               req0;
  logic               req1;
  logic [CNT_W-1:0]   half0;
  logic [CNT_W-1:0]   half1;
  logic [BURST_W-1:0] burst0;
  logic [BURST_W-1:0] burst1;
  logic               gnt0;
  logic               gnt1;
  logic               done0;
  logic               done1;
  logic               clk_out;
  logic               busy;

  modport master (
    output req0, req1, half0, half1, burst0, burst1,
    input  gnt0, gnt1, done0, done1, clk_out, busy
  );

  modport slave (
    input  req0, req1, half0, half1, burst0, burst1,
    output gnt0, gnt1, done0, done1, clk_out, busy
  );
endinterface

// File: rtl/div_sched.sv
// div_sched: two requesters share one programmable clock divider.
// A round-robin arbiter hands the divider to one requester at a time; the
// owner's half-period and burst length are latched in LOAD, the divider then
// produces 'burst' full clk_out periods of 2*(half+1) cycles, and a one-cycle
// done pulse closes the burst. One IDLE cycle separates consecutive bursts.
//
// Optional feature macro: DIV_SCHED_ABORT_EN
//   defined   -> the owner may cancel its burst by dropping req in LOAD/RUN;
//                the divider returns to IDLE silently (no done pulse).
//   undefined -> req is ignored once granted; bursts always complete.
module div_sched #(
  parameter int CNT_W   = 27,
  parameter int BURST_W = 8
) (
  input logic      clk_50m,
  input logic      rst,
  div_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  // Controller state: owner_q is the requester holding the divider
  // (0 = req0, 1 = req1); last_q is the requester served most recently and
  // steers the round-robin choice when both ask at once.
  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;

  // Divider datapath: latched half-period, remaining periods, phase counter.
  logic [CNT_W-1:0]   half_q, half_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               clk_out_q, clk_out_d;

  logic               any_req;
  logic               winner;
  logic               cnt_hit;
  logic [CNT_W-1:0]   sel_half;
  logic [BURST_W-1:0] sel_burst;
`ifdef DIV_SCHED_ABORT_EN
  logic               owner_req;
`endif

  // Round-robin arbitration: a lone requester wins; with both asking, the one
  // not served last wins. last_q resets to 1 so req0 is favoured first.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      winner = ~last_q;
    end else begin
      winner = bus.req1;
    end
  end

  // Select the current owner's settings; they only matter in LOAD.
  always_comb begin
    sel_half  = owner_q ? bus.half1  : bus.half0;
    sel_burst = owner_q ? bus.burst1 : bus.burst0;
    cnt_hit   = (div_cnt_q == half_q);
`ifdef DIV_SCHED_ABORT_EN
    owner_req = owner_q ? bus.req1 : bus.req0;
`endif
  end

  // Next-state and datapath update for the IDLE/LOAD/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    half_d    = half_q;
    rem_d     = rem_q;
    div_cnt_d = div_cnt_q;
    clk_out_d = clk_out_q;

    case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        div_cnt_d = '0;
        if (any_req) begin
          state_d = LOAD;
          owner_d = winner;
        end
      end

      LOAD: begin
        half_d    = sel_half;
        rem_d     = sel_burst;
        div_cnt_d = '0;
        clk_out_d = 1'b0;
        if (sel_burst == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (cnt_hit) begin
          div_cnt_d = '0;
          clk_out_d = ~clk_out_q;
          if (clk_out_q) begin
            rem_d = rem_q - BURST_ONE;
            if (rem_q == BURST_ONE) begin
              state_d = DONE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef DIV_SCHED_ABORT_EN
    if (((state_q == LOAD) || (state_q == RUN)) && !owner_req) begin
      state_d   = IDLE;
      clk_out_d = 1'b0;
      div_cnt_d = '0;
      rem_d     = '0;
      last_d    = owner_q;
    end
`endif
  end

  // State registers with synchronous reset; reset aborts any burst silently.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      half_q    <= '0;
      div_cnt_q <= '0;
      rem_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      half_q    <= half_d;
      div_cnt_q <= div_cnt_d;
      rem_q     <= rem_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.gnt0    = (state_q != IDLE) && !owner_q;
  assign bus.gnt1    = (state_q != IDLE) &&  owner_q;
  assign bus.done0   = (state_q == DONE) && !owner_q;
  assign bus.done1   = (state_q == DONE) &&  owner_q;
  assign bus.clk_out = clk_out_q;

  // Structural invariants of the scheduler outputs.
  a_gnt_exclusive : assert property (@(posedge clk_50m) disable iff (rst)
    !(bus.gnt0 && bus.gnt1));
  a_done_exclusive : assert property (@(posedge clk_50m) disable iff (rst)
    !(bus.done0 && bus.done1));
  a_clk_only_in_run : assert property (@(posedge clk_50m) disable iff (rst)
    (state_q != RUN) |-> !clk_out_q);

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: scoreboard bench for div_sched. Drivers push the expected
// burst (owner, half, burst, abort point) when they raise a request; a
// negedge monitor models arbitration, pops the entry when the grant starts
// and compares every output cycle by cycle until the grant ends.
// Honours DIV_SCHED_ABORT_EN the same way the design does.
module tb_div_sched;
  localparam int CNT_W   = 27;
  localparam int BURST_W = 8;
  localparam int LIMIT   = 400;

  typedef struct {
    int half;
    int burst;
    int abortOff;
  } expT;

  logic clk_50m;
  logic rst;

  div_sched_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  div_sched #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus)
  );

  expT expQ0[$];
  expT expQ1[$];
  int  grantLog[$];
  int  checkCount = 0;
  int  passCount  = 0;

  int  active    = 0;
  int  own       = 0;
  int  off       = 0;
  int  pendWin   = -1;
  int  modelLast = 1;
  expT cur;

  // 50 MHz clock
  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outVec();
    return {26'b0, bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.clk_out, bus.busy};
  endfunction

  function automatic logic [31:0] mkVec(input logic g1, input logic g0, input logic d1,
                                        input logic d0, input logic c, input logic b);
    return {26'b0, g1, g0, d1, d0, c, b};
  endfunction

  function automatic int rrWinner(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  function automatic void pushExp(input int idx, input int h, input int b, input int ab);
    expT e;
    e.half = h;
    e.burst = b;
    e.abortOff = ab;
    if (idx == 0) expQ0.push_back(e);
    else expQ1.push_back(e);
  endfunction

  function automatic void popFront(input int idx);
    expT tmp;
    if (idx == 0) begin
      if (expQ0.size() > 0) tmp = expQ0.pop_front();
    end else begin
      if (expQ1.size() > 0) tmp = expQ1.pop_front();
    end
  endfunction

  // Monitor: reference model of arbitration plus per-cycle burst waveform.
  always @(negedge clk_50m) begin
    int endOff;
    int k;
    logic expClk;
    logic expDone;
    logic hasEntry;
    if (rst) begin
      if (active != 0) popFront(own);
      active    = 0;
      pendWin   = -1;
      modelLast = 1;
    end else begin
      if (pendWin >= 0) begin
        hasEntry = (pendWin == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
        checkOutput("sbHasEntry", 32'(hasEntry), 32'd1);
        if (hasEntry) begin
          own = pendWin;
          cur = (own == 0) ? expQ0[0] : expQ1[0];
          active = 1;
          off = 0;
          grantLog.push_back(own);
        end
        pendWin = -1;
      end
      if (active != 0) begin
        endOff = (cur.abortOff > 0) ? cur.abortOff : 1 + 2 * (cur.half + 1) * cur.burst;
        if (off <= endOff) begin
          k = off - 1;
          expClk  = (off >= 1 && k < 2 * (cur.half + 1) * cur.burst) ? (((k / (cur.half + 1)) % 2) == 1) : 1'b0;
          expDone = (off == endOff) && (cur.abortOff == 0);
          checkOutput("burstOuts", outVec(),
                      mkVec(own == 1, own == 0, expDone && own == 1, expDone && own == 0, expClk, 1'b1));
          off++;
        end else begin
          popFront(own);
          modelLast = own;
          active = 0;
        end
      end
      if (active == 0) begin
        checkOutput("idleOuts", outVec(), 32'd0);
        if (bus.req0 || bus.req1) pendWin = rrWinner(bus.req0, bus.req1, modelLast);
      end
    end
  end

  task automatic setReq(input int idx, input logic r, input int h, input int b);
    if (idx == 0) begin
      bus.req0 = r;
      bus.half0 = CNT_W'(h);
      bus.burst0 = BURST_W'(b);
    end else begin
      bus.req1 = r;
      bus.half1 = CNT_W'(h);
      bus.burst1 = BURST_W'(b);
    end
  endtask

  task automatic waitDone(input int idx);
    logic got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(posedge clk_50m); #1;
      if ((idx == 0) ? bus.done0 : bus.done1) got = 1'b1;
    end
    checkOutput("doneSeen", 32'(got), 32'd1);
  endtask

  task automatic waitGnt(input int idx);
    logic got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(posedge clk_50m); #1;
      if ((idx == 0) ? bus.gnt0 : bus.gnt1) got = 1'b1;
    end
    checkOutput("gntSeen", 32'(got), 32'd1);
  endtask

  task automatic waitClkHigh();
    logic got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(posedge clk_50m); #1;
      if (bus.clk_out) got = 1'b1;
    end
    checkOutput("clkHighSeen", 32'(got), 32'd1);
  endtask

  task automatic applyReset();
    @(posedge clk_50m); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk_50m);
    #1;
    rst = 1'b0;
  endtask

  // One requester runs n back-to-back bursts, holding req between them.
  task automatic applyStimulus(input int idx, input int h, input int b, input int n);
    for (int i = 0; i < n; i++) begin
      setReq(idx, 1'b1, h, b);
      pushExp(idx, h, b, 0);
      waitDone(idx);
    end
    setReq(idx, 1'b0, h, b);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.half0 = '0;
    bus.half1 = '0;
    bus.burst0 = '0;
    bus.burst1 = '0;
    repeat (3) @(posedge clk_50m);
    #1;
    rst = 1'b0;
    idleCycles(2);

    $display("[TB] basic burst: half 1, burst 2");
    applyStimulus(0, 1, 2, 1);
    idleCycles(3);

    $display("[TB] round-robin with both requesting");
    applyReset();
    grantLog.delete();
    fork
      applyStimulus(0, 0, 1, 2);
      applyStimulus(1, 0, 1, 2);
    join
    idleCycles(3);
    checkOutput("altCount", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grantLog.size()) checkOutput("altOrder", 32'(grantLog[i]), 32'(i % 2));
    end

    $display("[TB] zero-length burst on req1");
    applyStimulus(1, 3, 0, 1);
    idleCycles(3);

    $display("[TB] req1 dropped mid-run");
    setReq(1, 1'b1, 4, 2);
`ifdef DIV_SCHED_ABORT_EN
    pushExp(1, 4, 2, 3);
`else
    pushExp(1, 4, 2, 0);
`endif
    waitGnt(1);
    repeat (3) @(posedge clk_50m);
    #1;
    bus.req1 = 1'b0;
`ifdef DIV_SCHED_ABORT_EN
    idleCycles(4);
`else
    waitDone(1);
`endif
    idleCycles(3);

    $display("[TB] settings changed mid-burst");
    setReq(0, 1'b1, 2, 2);
    pushExp(0, 2, 2, 0);
    waitGnt(0);
    repeat (2) @(posedge clk_50m);
    #1;
    bus.half0 = CNT_W'(7);
    bus.burst0 = BURST_W'(5);
    waitDone(0);
    setReq(0, 1'b0, 2, 2);
    idleCycles(3);

    $display("[TB] reset pulse while clk_out high");
    setReq(0, 1'b1, 1, 3);
    pushExp(0, 1, 3, 0);
    waitClkHigh();
    rst = 1'b1;
    @(posedge clk_50m); #1;
    rst = 1'b0;
    setReq(0, 1'b1, 1, 1);
    pushExp(0, 1, 1, 0);
    waitDone(0);
    setReq(0, 1'b0, 1, 1);
    idleCycles(3);

    $display("[TB] long half-period, single period");
    applyStimulus(0, 24, 1, 1);
    idleCycles(5);

    checkOutput("sbDrained0", 32'(expQ0.size()), 32'd0);
    checkOutput("sbDrained1", 32'(expQ1.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
